cnt_if: RTL and testbench

// - Loadable up/down binary counter with an all-ones (rollover) flag.
// - Generic event/sequence counter: a control block drives load, load_en and down.
// - The block holds the count register; consumers read count and rollover.

---
 rtl/cnt_if_if.sv | 40 ++++
 rtl/cnt_if.sv | 67 ++++++
 tb/tb_cnt_if.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cnt_if_if.sv
// ----------------------------------------------------------------------------
// cnt_if_if
// Handshake bundle between a control block and the cnt_if counter.
//
// Signals:
//   load_en   control -> counter   1 = load `load` into count on the next edge
//   load      control -> counter   parallel load value (WIDTH bits)
//   down      control -> counter   count direction: 1 = decrement, 0 = increment
//   count     counter -> consumers current counter value (registered)
//   rollover  counter -> consumers 1 while count is all ones
//
// Modports:
//   master  the control/consumer side (drives load_en/load/down)
//   slave   the counter side (drives count/rollover)
// ----------------------------------------------------------------------------
interface cnt_if_if #(
    parameter int WIDTH = 4
);
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             rollover;

    modport master (
        output load_en,
        output load,
        output down,
        input  count,
        input  rollover
    );

    modport slave (
        input  load_en,
        input  load,
        input  down,
        output count,
        output rollover
    );
endinterface : cnt_if_if

// File: rtl/cnt_if.sv
// ----------------------------------------------------------------------------
// cnt_if
// Loadable up/down binary counter with an all-ones (rollover) flag.
// A control block drives load/load_en/down through the bus interface; the
// block holds the count register and presents count and rollover.
//
// Parameters:
//   WIDTH     counter width in bits (>= 1); must match the bus WIDTH
//
// Ports:
//   clk       in   clock; every state update happens on its rising edge
//   rstn      in   synchronous reset, active HIGH despite the name
//                  (rstn=1 at a rising edge clears count to 0)
//   bus       slave modport of cnt_if_if:
//               load_en, load, down   in
//               count, rollover       out
//
// Behaviour per rising edge, highest priority first:
//   rstn=1     -> count <= 0
//   load_en=1  -> count <= load (down is ignored)
//   down=1     -> count <= count - 1 (wraps 0 -> all ones)
//   otherwise  -> count <= count + 1 (wraps all ones -> 0)
// rollover is combinational from count, so it rises in the same cycle the
// counter reaches all ones, however it got there.
// ----------------------------------------------------------------------------
module cnt_if #(
    parameter int WIDTH = 4
) (
    input  logic    clk,
    input  logic    rstn,
    cnt_if_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state selection. Reset is not handled here: it lives in the
    // register process so that its priority over everything is obvious.
    always_comb begin
        // NOTE: assign a default first so no path through the block leaves
        // count_d unassigned; otherwise a latch would be inferred.
        count_d = count_q;
        if (bus.load_en) begin
            count_d = bus.load;
        end else if (bus.down) begin
            // Unsigned subtraction truncated to WIDTH bits gives the 0 -> all ones wrap.
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its inputs from before the edge.
        if (rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.rollover = &count_q;

endmodule : cnt_if

// File: tb/tb_cnt_if.sv
// ----------------------------------------------------------------------------
// tb_cnt_if
// Self-checking bench for cnt_if (WIDTH = 4). Directed steps cover reset,
// wrap in both directions, load priority, reset priority and mid-cycle reset;
// randomized bursts are compared against a modulo-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_cnt_if;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic clk;
    logic rstn;

    cnt_if_if #(.WIDTH(WIDTH)) bus ();

    cnt_if #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: the counter value as plain integer arithmetic mod 2^WIDTH.
    int exp_count = 0;

    always @(posedge clk) begin
        if (rstn === 1'b1)
            exp_count = 0;
        else if (bus.load_en === 1'b1)
            exp_count = int'(bus.load);
        else if (bus.down === 1'b1)
            exp_count = (exp_count - 1 + MOD) % MOD;
        else
            exp_count = (exp_count + 1) % MOD;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Drive inputs, let one rising edge pass, then settle 1 ns past it.
    task automatic step(input logic rst, input logic le, input logic [WIDTH-1:0] ld, input logic dn);
        rstn        = rst;
        bus.load_en = le;
        bus.load    = ld;
        bus.down    = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic roll);
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".rollover"}, 32'(bus.rollover), 32'(roll));
    endtask

    initial begin
        rstn        = 1'b1;
        bus.load_en = 1'b0;
        bus.load    = '0;
        bus.down    = 1'b0;

        // Reset held for 5 clocks.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'h0, 1'b0);
            check_state("reset", 0, 1'b0);
        end

        // Release: counts 1, 2, 3.
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0);
            check_state("post_reset_up", i, 1'b0);
        end

        // Up wrap: E, F (rollover), 0.
        step(1'b0, 1'b1, 4'hE, 1'b0);
        check_state("upwrap_load", 'hE, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check_state("upwrap_F", 'hF, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check_state("upwrap_0", 0, 1'b0);

        // Down wrap: 1, 0, F (rollover), E.
        step(1'b0, 1'b1, 4'h1, 1'b0);
        check_state("dnwrap_load", 1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check_state("dnwrap_0", 0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check_state("dnwrap_F", 'hF, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check_state("dnwrap_E", 'hE, 1'b0);

        // Load priority over down, held 3 clocks, then decrement.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h5, 1'b1);
            check_state("load_prio", 5, 1'b0);
        end
        step(1'b0, 1'b0, 4'h5, 1'b1);
        check_state("load_release", 4, 1'b0);

        // Load straight to all ones raises rollover.
        step(1'b0, 1'b1, 4'hF, 1'b0);
        check_state("load_F", 'hF, 1'b1);

        // Reset wins over load.
        step(1'b1, 1'b1, 4'hA, 1'b0);
        check_state("reset_prio", 0, 1'b0);

        // Reset raised between edges has no effect until the next edge.
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check_state("pre_midreset", 1, 1'b0);
        rstn = 1'b1;
        #3;
        check_state("midreset_hold", 1, 1'b0);
        @(posedge clk);
        #1;
        check_state("midreset_edge", 0, 1'b0);

        // Randomized bursts against the reference model.
        for (int b = 0; b < 5; b++) begin
            int len;
            len = int'($urandom_range(10, 20));
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 3) == 0),
                     WIDTH'($urandom_range(0, MOD - 1)),
                     1'($urandom_range(0, 1)));
                check_state("random", exp_count, 1'(exp_count == MOD - 1));
            end
            // Gap with inputs held; the model keeps tracking any edges inside it.
            #($urandom_range(1, 30));
            @(posedge clk);
            #1;
            check_state("random_gap", exp_count, 1'(exp_count == MOD - 1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_cnt_if
